// File: rtl/aes_ks_arbiter.sv
// Keystream arbiter: shares one AES-CTR core between the jawny and tajny
// frame paths, sequences the core's control pins and returns its blocks.
//
// state  | meaning
// IDLE   | no service; arbitrate pending requests, reject bad ones
// LOAD   | core held in reset, new nonce, key and nonce presented
// SETTLE | reset and new_nonce released, one cycle for the core to settle
// RUN    | start_aes high, forward each taken block, watch for a stall
// STOP   | one-cycle stop_aes with done or timeout error, then release gnt
module aes_ks_arbiter #(
  parameter logic [127:0] KEY0    = 128'h0,
  parameter logic [127:0] KEY1    = {128{1'b1}},
  parameter int unsigned  TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_j,
  input  logic         req_t,
  input  logic [7:0]   id_j,
  input  logic [7:0]   id_t,
  input  logic [95:0]  nonce_j,
  input  logic [95:0]  nonce_t,
  input  logic [3:0]   nblk_j,
  input  logic [3:0]   nblk_t,
  output logic         gnt_j,
  output logic         gnt_t,
  output logic [127:0] ks_data,
  output logic         ks_valid,
  output logic         ks_last,
  output logic         done_j,
  output logic         done_t,
  output logic         err,
  output logic [1:0]   err_code,
  output logic         res_aes,
  output logic         new_nonce,
  output logic         start_aes,
  output logic         stop_aes,
  output logic [127:0] key_in,
  output logic [95:0]  nonce_aes,
  input  logic         take_aes,
  input  logic [127:0] ciphertext_aes
);

  localparam int unsigned   IW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, STOP} state_t;

  state_t          state_q, state_d;
  logic            last_t_q, last_t_d;   // 1: tajny was served last
  logic            sel_t_q, sel_t_d;     // 1: tajny is being served
  logic [3:0]      nblk_q, nblk_d;
  logic [3:0]      blk_cnt_q, blk_cnt_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;

  logic            gnt_j_d, gnt_t_d, ks_valid_d, ks_last_d, done_j_d, done_t_d;
  logic            err_d, res_aes_d, new_nonce_d, start_aes_d, stop_aes_d;
  logic [1:0]      err_code_d;
  logic [127:0]    ks_data_d, key_in_d;
  logic [95:0]     nonce_aes_d;

  logic            pick_t;
  logic [7:0]      pick_id;
  logic [3:0]      pick_nblk;
  logic [95:0]     pick_nonce;

  // Round-robin choice: a lone request wins, contention goes to the path not served last.
  assign pick_t     = req_t & (~req_j | ~last_t_q);
  assign pick_id    = pick_t ? id_t    : id_j;
  assign pick_nblk  = pick_t ? nblk_t  : nblk_j;
  assign pick_nonce = pick_t ? nonce_t : nonce_j;

  // Next-state and next-output logic; pulses default low, held values default to hold.
  always_comb begin
    state_d     = state_q;
    last_t_d    = last_t_q;
    sel_t_d     = sel_t_q;
    nblk_d      = nblk_q;
    blk_cnt_d   = blk_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    gnt_j_d     = gnt_j;
    gnt_t_d     = gnt_t;
    ks_data_d   = ks_data;
    ks_valid_d  = 1'b0;
    ks_last_d   = 1'b0;
    done_j_d    = 1'b0;
    done_t_d    = 1'b0;
    err_d       = 1'b0;
    err_code_d  = 2'b00;
    res_aes_d   = 1'b0;
    new_nonce_d = 1'b0;
    start_aes_d = 1'b0;
    stop_aes_d  = 1'b0;
    key_in_d    = key_in;
    nonce_aes_d = nonce_aes;
    case (state_q)
      IDLE: begin
        if (req_j || req_t) begin
          last_t_d = pick_t;
          if (pick_id[7:1] != 7'd0) begin
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end else if (pick_nblk == 4'd0) begin
            err_d      = 1'b1;
            err_code_d = 2'b11;
          end else begin
            state_d     = LOAD;
            sel_t_d     = pick_t;
            nblk_d      = pick_nblk;
            gnt_j_d     = ~pick_t;
            gnt_t_d     = pick_t;
            res_aes_d   = 1'b1;
            new_nonce_d = 1'b1;
            key_in_d    = pick_id[0] ? KEY1 : KEY0;
            nonce_aes_d = pick_nonce;
          end
        end
      end
      LOAD: state_d = SETTLE;
      SETTLE: begin
        state_d     = RUN;
        start_aes_d = 1'b1;
      end
      RUN: begin
        start_aes_d = 1'b1;
        // A take on the timeout cycle still counts as progress.
        if (take_aes) begin
          ks_data_d  = ciphertext_aes;
          ks_valid_d = 1'b1;
          blk_cnt_d  = blk_cnt_q + 4'd1;
          idle_cnt_d = '0;
          if (blk_cnt_q + 4'd1 == nblk_q) begin
            state_d     = STOP;
            ks_last_d   = 1'b1;
            start_aes_d = 1'b0;
            stop_aes_d  = 1'b1;
            done_j_d    = ~sel_t_q;
            done_t_d    = sel_t_q;
          end
        end else if (idle_cnt_q == IDLE_MAX) begin
          state_d     = STOP;
          start_aes_d = 1'b0;
          stop_aes_d  = 1'b1;
          err_d       = 1'b1;
          err_code_d  = 2'b01;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      STOP: begin
        state_d     = IDLE;
        gnt_j_d     = 1'b0;
        gnt_t_d     = 1'b0;
        key_in_d    = '0;
        nonce_aes_d = '0;
        blk_cnt_d   = '0;
        idle_cnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything, last_served points at tajny.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_t_q   <= 1'b1;
      sel_t_q    <= 1'b0;
      nblk_q     <= '0;
      blk_cnt_q  <= '0;
      idle_cnt_q <= '0;
      gnt_j      <= 1'b0;
      gnt_t      <= 1'b0;
      ks_data    <= '0;
      ks_valid   <= 1'b0;
      ks_last    <= 1'b0;
      done_j     <= 1'b0;
      done_t     <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      res_aes    <= 1'b0;
      new_nonce  <= 1'b0;
      start_aes  <= 1'b0;
      stop_aes   <= 1'b0;
      key_in     <= '0;
      nonce_aes  <= '0;
    end else begin
      state_q    <= state_d;
      last_t_q   <= last_t_d;
      sel_t_q    <= sel_t_d;
      nblk_q     <= nblk_d;
      blk_cnt_q  <= blk_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      gnt_j      <= gnt_j_d;
      gnt_t      <= gnt_t_d;
      ks_data    <= ks_data_d;
      ks_valid   <= ks_valid_d;
      ks_last    <= ks_last_d;
      done_j     <= done_j_d;
      done_t     <= done_t_d;
      err        <= err_d;
      err_code   <= err_code_d;
      res_aes    <= res_aes_d;
      new_nonce  <= new_nonce_d;
      start_aes  <= start_aes_d;
      stop_aes   <= stop_aes_d;
      key_in     <= key_in_d;
      nonce_aes  <= nonce_aes_d;
    end
  end

endmodule
